// File: rtl/key_event_pkg.sv
// Shared encodings and default timing for the key event decoder.
package key_event_pkg;

  // Gesture FSM state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HELD1    = 2'd1;
  localparam logic [1:0] ST_GAP      = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  // Default timing at 50 MHz: 1 s long press, 250 ms double-click window
  localparam int LONG_CYCLES_DEF = 50_000_000;
  localparam int DOUBLE_GAP_DEF  = 12_500_000;
  localparam int CNT_W_DEF       = 26;

endpackage

// File: rtl/key_event_decoder_timer.sv
// Interval counter with synchronous clear, count enable and terminal-count compare.
module interval_timer
  import key_event_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear wins over enable; otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc  = (cnt_q == term);
  assign cnt = cnt_q;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced button gestures into single / double / long 1-cycle pulses.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int DOUBLE_GAP  = DOUBLE_GAP_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_p,
  input  logic btn_level,
  output logic single_p,
  output logic double_p,
  output logic long_p,
  output logic busy
);

  // Thresholds are compared as parameter-1, truncated to counter width
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP - 1);

  logic [1:0]       state_d, state_q;
  logic             single_d, single_q;
  logic             double_d, double_q;
  logic             long_d, long_q;
  logic             busy_d, busy_q;
  logic             tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_term;
  logic [CNT_W-1:0] tmr_cnt;

  // One counter serves both timed states; threshold follows the state
  assign tmr_term = (state_q == ST_HELD1) ? LONG_TERM : GAP_TERM;

  interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~tmr_en),
    .en    (tmr_en),
    .term  (tmr_term),
    .tc    (tmr_tc),
    .cnt   (tmr_cnt)
  );

  // Gesture FSM: release beats long threshold, second press beats gap timeout
  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_p) state_d = ST_HELD1;
      end
      ST_HELD1: begin
        if (!btn_level) begin
          state_d = ST_GAP;
        end else if (tmr_tc) begin
          long_d  = 1'b1;
          state_d = ST_WAIT_REL;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (press_p) begin
          double_d = 1'b1;
          state_d  = ST_WAIT_REL;
        end else if (tmr_tc) begin
          single_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        if (!btn_level) state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any gesture in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

  assign single_p = single_q;
  assign double_p = double_q;
  assign long_p   = long_q;
  assign busy     = busy_q;

endmodule
